// File: rtl/alu_trojan_monitor.sv
// Purpose: recompute each ALU transaction with a golden model; count mismatches, capture the first, raise a sticky alarm.
// Latency: valid at edge N -> pulse/count/capture/alarm updated at edge N+1.
// Backpressure: none; accepts one transaction per cycle, clear flushes the pipeline.
module alu_trojan_monitor #(
    parameter int MISMATCH_THRESH = 4,
    parameter int CNT_W           = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             valid,
    input  logic [3:0]       A,
    input  logic [3:0]       B,
    input  logic [1:0]       op,
    input  logic [3:0]       result,
    input  logic             carry,
    input  logic             zero,
    input  logic             overflow,
    input  logic             clear,
    output logic             mismatch_pulse,
    output logic [CNT_W-1:0] mismatch_count,
    output logic             alarm,
    output logic             fail_captured,
    output logic [1:0]       fail_op,
    output logic [3:0]       fail_a,
    output logic [3:0]       fail_b,
    output logic [3:0]       fail_result
);

    typedef struct packed {
        logic [1:0] op;
        logic [3:0] a;
        logic [3:0] b;
        logic [3:0] result;
        logic       carry;
        logic       zero;
        logic       overflow;
    } txn_t;

    typedef enum logic {MONITOR = 1'b0, ALARM = 1'b1} state_t;

    state_t           state, state_nxt;
    txn_t             s1_dat;
    logic             s1_vld;
    logic [4:0]       sum;
    logic [3:0]       exp_result;
    logic             exp_carry, exp_zero, exp_overflow;
    logic             mismatch;
    logic [CNT_W-1:0] cnt_inc;

    // Golden model evaluated on the S1 snapshot
    always_comb begin
        sum          = '0;
        exp_result   = '0;
        exp_carry    = 1'b0;
        exp_overflow = 1'b0;
        case (s1_dat.op)
            2'b00: begin
                sum          = {1'b0, s1_dat.a} + {1'b0, s1_dat.b};
                exp_result   = sum[3:0];
                exp_carry    = sum[4];
                exp_overflow = (s1_dat.a[3] == s1_dat.b[3]) && (exp_result[3] != s1_dat.a[3]);
            end
            2'b01: begin
                exp_result   = s1_dat.a - s1_dat.b;
                exp_carry    = s1_dat.a < s1_dat.b;
                exp_overflow = (s1_dat.a[3] != s1_dat.b[3]) && (exp_result[3] != s1_dat.a[3]);
            end
            2'b10:   exp_result = s1_dat.a & s1_dat.b;
            default: exp_result = s1_dat.a | s1_dat.b;
        endcase
        exp_zero = (exp_result == 4'd0);
    end

    assign mismatch = s1_vld && ((s1_dat.result   != exp_result) ||
                                 (s1_dat.carry    != exp_carry)  ||
                                 (s1_dat.zero     != exp_zero)   ||
                                 (s1_dat.overflow != exp_overflow));

    assign cnt_inc = (mismatch_count == {CNT_W{1'b1}}) ? mismatch_count : mismatch_count + 1'b1;

    always_comb begin
        state_nxt = state;
        if (clear) begin
            state_nxt = MONITOR;
        end else if (state == MONITOR && mismatch && cnt_inc >= CNT_W'(MISMATCH_THRESH)) begin
            state_nxt = ALARM;
        end
    end

    assign alarm = (state == ALARM);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= MONITOR;
        end else begin
            state <= state_nxt;
        end
    end

    // clear wins over both the incoming transaction and a mismatch resolving this cycle
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_vld         <= 1'b0;
            s1_dat         <= '0;
            mismatch_pulse <= 1'b0;
            mismatch_count <= '0;
            fail_captured  <= 1'b0;
            fail_op        <= '0;
            fail_a         <= '0;
            fail_b         <= '0;
            fail_result    <= '0;
        end else if (clear) begin
            s1_vld         <= 1'b0;
            mismatch_pulse <= 1'b0;
            mismatch_count <= '0;
            fail_captured  <= 1'b0;
            fail_op        <= '0;
            fail_a         <= '0;
            fail_b         <= '0;
            fail_result    <= '0;
        end else begin
            s1_vld         <= valid;
            mismatch_pulse <= mismatch;
            if (valid) begin
                s1_dat <= '{op: op, a: A, b: B, result: result,
                            carry: carry, zero: zero, overflow: overflow};
            end
            if (mismatch) begin
                mismatch_count <= cnt_inc;
                if (!fail_captured) begin
                    fail_captured <= 1'b1;
                    fail_op       <= s1_dat.op;
                    fail_a        <= s1_dat.a;
                    fail_b        <= s1_dat.b;
                    fail_result   <= s1_dat.result;
                end
            end
        end
    end

endmodule

// File: doc/alu_trojan_monitor.md
# alu_trojan_monitor

Runtime checker placed directly downstream of the secure ALU wrapper. Samples each ALU transaction (operands, opcode, and the four ALU outputs), recomputes the expected outputs with an internal golden model, and flags any disagreement. Counts mismatches, captures the first failing transaction, and raises a sticky alarm once a threshold is reached, so that any Trojan variant linked into the ALU is detectable at run time.

## Interface
Parameters:
- MISMATCH_THRESH, default 4: mismatch count at which alarm asserts; legal range 1 to 2^CNT_W-1.
- CNT_W, default 8: width of the mismatch counter.

Ports:
- clk  in  1  single clock, rising edge.
- rst_n  in  1  reset, asynchronous, active-low.
- valid  in  1  the current A/B/op and ALU outputs form a transaction to check.
- A  in  4  ALU operand A.
- B  in  4  ALU operand B.
- op  in  2  ALU opcode.
- result  in  4  observed ALU result.
- carry  in  1  observed ALU carry flag.
- zero  in  1  observed ALU zero flag.
- overflow  in  1  observed ALU overflow flag.
- clear  in  1  synchronous clear of count, capture, alarm and pipeline.
- mismatch_pulse  out  1  one-cycle pulse per mismatching transaction.
- mismatch_count  out  CNT_W  saturating mismatch count.
- alarm  out  1  sticky; set when mismatch_count reaches MISMATCH_THRESH.
- fail_captured  out  1  first-failure capture registers are valid.
- fail_op  out  2  opcode of the first failing transaction.
- fail_a  out  4  A of the first failing transaction.
- fail_b  out  4  B of the first failing transaction.
- fail_result  out  4  observed result of the first failing transaction.

## Operation
- Golden model, 4-bit unsigned arithmetic, exp_zero = (exp_result == 0) for all ops:
  - op 00 ADD: {exp_carry, exp_result} = A + B (5-bit sum); exp_overflow = (A[3] == B[3]) && (exp_result[3] != A[3]).
  - op 01 SUB: exp_result = (A - B) mod 16; exp_carry = (A < B) (borrow); exp_overflow = (A[3] != B[3]) && (exp_result[3] != A[3]).
  - op 10 AND and op 11 OR: bitwise; exp_carry = 0, exp_overflow = 0.
- Stage 1 (S1): on valid, register A, B, op, result, carry, zero, overflow and set s1_valid. With valid low, s1_valid is cleared.
- Stage 2 (S2): if s1_valid, compute the golden model from the S1 operands and compare all four outputs. Any difference is a mismatch.
- On a mismatch:
  - mismatch_pulse is 1 for exactly one cycle.
  - mismatch_count increments, saturating at 2^CNT_W-1.
  - If fail_captured is 0, load fail_op, fail_a, fail_b and fail_result and set fail_captured. Later mismatches do not overwrite the capture.
- State machine:
  - MONITOR → ALARM on the edge where the updated count is ≥ MISMATCH_THRESH.
  - ALARM → MONITOR only on clear.
  - alarm = (state == ALARM).
  - Checking and counting continue while in ALARM.
- clear: zeroes the count, capture, fail_captured and s1_valid, and forces MONITOR.
  - clear beats a mismatch arriving in the same cycle: no pulse, nothing counted.
  - valid asserted in the same cycle as clear is discarded.

## Timing
- Reset values: every output and internal register is 0; state is MONITOR.
- Reset is asynchronous. Asserting it mid-pipeline discards any in-flight transaction.
- Latency: valid at edge N → S1 registered at N → mismatch_pulse, count, capture and alarm all updated at edge N+1 and visible during cycle N+1.
- Throughput: one transaction per cycle; back-to-back valid is fully supported.
- alarm asserts in the same cycle as the mismatch_pulse for the MISMATCH_THRESH-th mismatch.
- At saturation, mismatch_pulse still fires but the count holds.

## Test plan
- **Clean ADD:** A=7, B=9, op=00, result=0, carry=1, zero=1, overflow=0, valid for 1 cycle → no mismatch_pulse; count stays 0.
- **Wrong result:** A=3, B=2, op=00, result=6 (expected 5), other flags correct → mismatch_pulse one cycle after valid; count=1; fail_captured=1, fail_op=00, fail_a=3, fail_b=2, fail_result=6.
- **Threshold and first capture:** 4 back-to-back mismatches with default THRESH=4 → alarm rises with the 4th pulse. Capture still holds the first transaction.
- **Flag-only mismatch:** SUB A=8, B=1, op=01, result=7, carry=0, zero=0, overflow=0 (expected overflow=1) → mismatch detected. Count saturation check: CNT_W=2 with 5 mismatches → count holds at 3.
- **Clear collision:** clear in the same cycle a mismatch reaches S2 → count=0, alarm=0, fail_captured=0, no pulse. A subsequent mismatch counts from 1.
- **Reset mid-pipeline:** assert rst_n low between valid and S2 → all outputs 0 immediately. No pulse after reset is released.
